// File: rtl/rom_boot_loader.sv
// Boot loader: takes a framed byte stream (sync, 16-bit word count, LE payload, mod-256 checksum),
// writes the words into the instruction ROM, then releases core reset. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module rom_boot_loader #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  // Handshake: a byte transfers on a clk edge where rx_valid && rx_ready; rx_ready depends only on state.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t      state, state_next;
  logic        ready_en;
  logic        accept;
  logic        is_sync;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [7:0]  csum;
  logic [16:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        last_word;
  logic        timeout_hit;

  assign accept    = rx_valid && rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign len_in    = {rx_data, len_lo};
  assign last_word = ((word_cnt + 17'd1) == {1'b0, len});

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_active;

  assign tmo_active  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
  assign timeout_hit = tmo_active && !accept && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Restarts on every accepted byte and on every state change, so it measures the current silence only.
  always_ff @(posedge clk) begin
    if (rst || !tmo_active || accept || (state_next != state)) tmo_cnt <= '0;
    else                                                       tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ready_en  <= 1'b0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      len_lo    <= '0;
      len       <= '0;
      csum      <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      rom_we   <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE, S_ERR: begin
            if (is_sync) begin
              csum      <= '0;
              word_cnt  <= '0;
              byte_cnt  <= '0;
              rom_waddr <= '0;
            end
          end
          S_LEN0: len_lo <= rx_data;
          S_LEN1: len    <= len_in;
          S_DATA: begin
            csum     <= csum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                rom_we    <= 1'b1;
                rom_wdata <= {rx_data, word_buf};
                rom_waddr <= word_cnt[ADDR_W-1:0];
                word_cnt  <= word_cnt + 17'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && is_sync) state_next = S_LEN0;
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if ({1'b0, len_in} > CAP)  state_next = S_ERR;
          else if (len_in == 16'd0)  state_next = S_CSUM;
          else                       state_next = S_DATA;
        end
      end
      S_DATA: if (accept && (byte_cnt == 2'd3) && last_word) state_next = S_CSUM;
      S_CSUM: if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
      S_DONE: state_next = S_DONE;
      S_ERR:  if (accept && is_sync) state_next = S_LEN0;
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_ERR;
  end

  always_comb begin
    rx_ready   = ready_en && (state != S_DONE);
    load_done  = (state == S_DONE);
    core_rst_n = (state == S_DONE);
    load_err   = (state == S_ERR);
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: random frames built from the framing rules, expected ROM writes in a queue.
`timescale 1ns/1ps
module tb_rom_boot_loader;

  localparam int         ADDR_W = 12;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         CAPW   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [31:0]        pay[$];

  rom_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every ROM write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && rom_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_we", {52'd0, rom_waddr}, 64'hFFFF);
      else begin
        mon_e = exp_q.pop_front();
        check("rom_write", {20'd0, rom_waddr, rom_wdata}, {20'd0, mon_e});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("rst_rom_we", {63'd0, rom_we}, 64'd0);
    check("rst_waddr", {52'd0, rom_waddr}, 64'd0);
    check("rst_wdata", {32'd0, rom_wdata}, 64'd0);
    check("rst_core_rst_n", {63'd0, core_rst_n}, 64'd0);
    check("rst_done", {63'd0, load_done}, 64'd0);
    check("rst_err", {63'd0, load_err}, 64'd0);
    check("rst_pending", exp_q.size(), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {63'd0, rx_ready}, 64'd1);
    check("core_held", {63'd0, core_rst_n}, 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("rx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  // Sends a whole frame from pay[]; stop_after >= 0 cuts it after that many payload bytes.
  task automatic send_frame(input int n, input bit csum_ok, input int max_gap, input int stop_after);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    int k = 0;
    logic [15:0] n16 = n[15:0];
    send_byte(SYNC, $urandom_range(0, max_gap));
    send_byte(n16[7:0], $urandom_range(0, max_gap));
    send_byte(n16[15:8], $urandom_range(0, max_gap));
    if (n > CAPW) begin
      rx_valid = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (stop_after >= 0 && k == stop_after) return;
        b = pay[i][8*j +: 8];
        if (j == 3) exp_q.push_back({i[ADDR_W-1:0], pay[i]});
        sum = sum + b;
        send_byte(b, $urandom_range(0, max_gap));
        k++;
      end
    end
    send_byte(csum_ok ? sum : (sum ^ 8'h5A), $urandom_range(0, max_gap));
    rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    check({tag, "_done"}, {63'd0, load_done}, {63'd0, done});
    check({tag, "_err"}, {63'd0, load_err}, {63'd0, err});
    check({tag, "_core_rst_n"}, {63'd0, core_rst_n}, {63'd0, done});
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, {63'd0, !done});
    check({tag, "_writes_left"}, exp_q.size(), 64'd0);
  endtask

  task automatic random_payload(input int n);
    pay.delete();
    for (int i = 0; i < n; i++)
      pay.push_back(($urandom_range(0, 3) == 0) ? 32'hA5A5A5A5 : $urandom);
  endtask

  initial begin
    do_reset();

    // known frame, continuous valid
    pay.delete();
    pay.push_back(32'h00100513);
    pay.push_back(32'h00200593);
    send_frame(2, 1'b1, 0, -1);
    check_status("good", 1'b1, 1'b0);
    rx_valid = 1'b1;
    rx_data  = SYNC;
    repeat (8) @(negedge clk);
    rx_valid = 1'b0;
    check_status("after_done", 1'b1, 1'b0);

    // bad checksum, then a good frame straight from the error state
    do_reset();
    send_frame(2, 1'b0, 0, -1);
    check_status("bad_csum", 1'b0, 1'b1);
    random_payload(3);
    send_frame(3, 1'b1, 2, -1);
    check_status("recover", 1'b1, 1'b0);

    // empty frame and length overflow
    do_reset();
    send_frame(0, 1'b1, 1, -1);
    check_status("n_zero", 1'b1, 1'b0);
    do_reset();
    send_frame(CAPW + 1, 1'b1, 0, -1);
    check_status("overflow", 1'b0, 1'b1);

    // random frames with gaps and non-sync noise ahead of the sync byte
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int g = 0; g < 3; g++) begin
        rx_data = 8'($urandom_range(0, 255));
        send_byte((rx_data == SYNC) ? 8'h00 : rx_data, $urandom_range(0, 5));
      end
      random_payload($urandom_range(1, 8));
      send_frame(pay.size(), ($urandom_range(0, 3) != 0), 5, -1);
      check("rand_status", {62'd0, load_done, load_err} != 2'b00, 64'd1);
      check("rand_writes_left", exp_q.size(), 64'd0);
    end

    // abort mid-frame, then a fresh frame from address 0
    do_reset();
    random_payload(3);
    send_frame(3, 1'b1, 2, 6);
    do_reset();
    random_payload(2);
    send_frame(2, 1'b1, 3, -1);
    check_status("after_abort", 1'b1, 1'b0);

    // full-capacity frame
    do_reset();
    random_payload(CAPW);
    send_frame(CAPW, 1'b1, 0, -1);
    check_status("full", 1'b1, 1'b0);

`ifdef LOADER_TIMEOUT_EN
    do_reset();
    send_byte(SYNC, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    rx_valid = 1'b0;
    repeat (45) @(negedge clk);
    check("tmo_early_err", {63'd0, load_err}, 64'd0);
    repeat (15) @(negedge clk);
    check("tmo_err", {63'd0, load_err}, 64'd1);
    do_reset();
    pay.delete();
    pay.push_back(32'hDEADBEEF);
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 40);
    exp_q.push_back({12'd0, 32'hDEADBEEF});
    send_byte(8'hEF, 40);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 40);
    send_byte(8'hDE, 0);
    send_byte(8'hEF + 8'hBE + 8'hAD + 8'hDE, 40);
    rx_valid = 1'b0;
    check_status("tmo_ok", 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
